// File: rtl/transpose_buffer_pp.sv
// Ping-pong transpose buffer: NxN blocks arrive row-major and leave
// column-major (or row-major when the block was flagged bypass).
// Two RAM banks alternate between the write and read sides. A 2-entry
// skid FIFO behind the synchronous-read RAM keeps outputs stable under
// back-pressure and allows one sample per cycle.
module transpose_buffer_pp #(
   parameter int DATA_W = 12,
   parameter int LOG2_N = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_bypass,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   output logic              out_bypass
);

   localparam int CNT_W  = 2 * LOG2_N;
   localparam int ADDR_W = CNT_W + 1;
   localparam int DEPTH  = 1 << ADDR_W;
   localparam logic [CNT_W-1:0] CNT_LAST = '1;
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   // write side
   logic             wbank_q, wbank_d;
   logic [CNT_W-1:0] w_cnt_q, w_cnt_d;
   logic [1:0]       full_q, full_d;
   logic [1:0]       byp_q, byp_d;
   // read side
   logic             rbank_q, rbank_d;
   logic [CNT_W-1:0] r_cnt_q, r_cnt_d;
   logic             pend_q, pend_d;
   logic             pend_last_q, pend_last_d;
   logic             pend_byp_q, pend_byp_d;
   // skid FIFO
   logic [1:0][DATA_W-1:0] fifo_data_q, fifo_data_d;
   logic [1:0]             fifo_last_q, fifo_last_d;
   logic [1:0]             fifo_byp_q, fifo_byp_d;
   logic                   head_q, head_d;
   logic [1:0]             cnt_q, cnt_d;

   // RAM and combinational control
   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] ram_dout;
   logic [ADDR_W-1:0] waddr, raddr;
   logic              wr_fire, rd_fire, wr_en, rd_en;
   logic              pop, direct, fifo_pop, push, widx;
   logic [1:0]        occ;

   // Two-bank storage; reads and writes never touch the same bank at once
   always_ff @(posedge clk) begin
      if (wr_en) mem[waddr] <= in_data;
      if (rd_en) ram_dout <= mem[raddr];
   end

   // Handshakes, addresses and output presentation
   always_comb begin
      in_ready   = !full_q[wbank_q];
      wr_fire    = in_valid && in_ready;
      waddr      = {wbank_q, w_cnt_q};
      out_valid  = 1'b0;
      out_data   = '0;
      out_last   = 1'b0;
      out_bypass = 1'b0;
      // FIFO head has priority; an empty FIFO passes the RAM word straight through
      if (cnt_q != 2'd0) begin
         out_valid  = 1'b1;
         out_data   = fifo_data_q[head_q];
         out_last   = fifo_last_q[head_q];
         out_bypass = fifo_byp_q[head_q];
      end else if (pend_q) begin
         out_valid  = 1'b1;
         out_data   = ram_dout;
         out_last   = pend_last_q;
         out_bypass = pend_byp_q;
      end
      pop      = out_valid && out_ready;
      direct   = pop && (cnt_q == 2'd0);
      fifo_pop = pop && (cnt_q != 2'd0);
      push     = pend_q && !direct;
      widx     = head_q ^ cnt_q[0];
      occ      = cnt_q + {1'b0, pend_q};
      // never let FIFO entries plus the in-flight read exceed two
      rd_fire  = full_q[rbank_q] && ((occ < 2'd2) || pop);
      if (byp_q[rbank_q])
         raddr = {rbank_q, r_cnt_q};
      else
         raddr = {rbank_q, r_cnt_q[LOG2_N-1:0], r_cnt_q[CNT_W-1:LOG2_N]};
      wr_en = wr_fire && !clr;
      rd_en = rd_fire && !clr;
   end

   // Next-state for bank bookkeeping, read issue and skid FIFO
   always_comb begin
      wbank_d     = wbank_q;
      w_cnt_d     = w_cnt_q;
      full_d      = full_q;
      byp_d       = byp_q;
      rbank_d     = rbank_q;
      r_cnt_d     = r_cnt_q;
      pend_d      = 1'b0;
      pend_last_d = pend_last_q;
      pend_byp_d  = pend_byp_q;
      fifo_data_d = fifo_data_q;
      fifo_last_d = fifo_last_q;
      fifo_byp_d  = fifo_byp_q;
      head_d      = head_q ^ fifo_pop;
      cnt_d       = cnt_q;

      if (wr_fire) begin
         w_cnt_d = w_cnt_q + CNT_ONE;
         if (w_cnt_q == '0) byp_d[wbank_q] = in_bypass;
         if (w_cnt_q == CNT_LAST) begin
            full_d[wbank_q] = 1'b1;
            wbank_d         = ~wbank_q;
         end
      end

      // the write completes one bank while the read may release the other
      if (rd_fire) begin
         r_cnt_d     = r_cnt_q + CNT_ONE;
         pend_d      = 1'b1;
         pend_last_d = (r_cnt_q == CNT_LAST);
         pend_byp_d  = byp_q[rbank_q];
         if (r_cnt_q == CNT_LAST) begin
            full_d[rbank_q] = 1'b0;
            rbank_d         = ~rbank_q;
         end
      end

      if (push) begin
         fifo_data_d[widx] = ram_dout;
         fifo_last_d[widx] = pend_last_q;
         fifo_byp_d[widx]  = pend_byp_q;
      end

      case ({push, fifo_pop})
         2'b10:   cnt_d = cnt_q + 2'd1;
         2'b01:   cnt_d = cnt_q - 2'd1;
         default: cnt_d = cnt_q;
      endcase

      if (clr) begin
         wbank_d     = 1'b0;
         w_cnt_d     = '0;
         full_d      = '0;
         byp_d       = '0;
         rbank_d     = 1'b0;
         r_cnt_d     = '0;
         pend_d      = 1'b0;
         pend_last_d = 1'b0;
         pend_byp_d  = 1'b0;
         fifo_data_d = '0;
         fifo_last_d = '0;
         fifo_byp_d  = '0;
         head_d      = 1'b0;
         cnt_d       = '0;
      end
   end

   // State registers with asynchronous reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wbank_q     <= 1'b0;
         w_cnt_q     <= '0;
         full_q      <= '0;
         byp_q       <= '0;
         rbank_q     <= 1'b0;
         r_cnt_q     <= '0;
         pend_q      <= 1'b0;
         pend_last_q <= 1'b0;
         pend_byp_q  <= 1'b0;
         fifo_data_q <= '0;
         fifo_last_q <= '0;
         fifo_byp_q  <= '0;
         head_q      <= 1'b0;
         cnt_q       <= '0;
      end else begin
         wbank_q     <= wbank_d;
         w_cnt_q     <= w_cnt_d;
         full_q      <= full_d;
         byp_q       <= byp_d;
         rbank_q     <= rbank_d;
         r_cnt_q     <= r_cnt_d;
         pend_q      <= pend_d;
         pend_last_q <= pend_last_d;
         pend_byp_q  <= pend_byp_d;
         fifo_data_q <= fifo_data_d;
         fifo_last_q <= fifo_last_d;
         fifo_byp_q  <= fifo_byp_d;
         head_q      <= head_d;
         cnt_q       <= cnt_d;
      end
   end

endmodule
